// File: rtl/wishbone_master_arbiter_pkg.sv
// rtl/wishbone_master_arbiter_pkg.sv - FSM type, constants and pointer helper for the arbiter
`include "wishbone_arbiter_defs.v"

package wishbone_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `ARB_IDLE,
        ST_OWN  = `ARB_OWN,
        ST_GAP  = `ARB_GAP
    } arb_state_t;

    localparam int          MAX_MASTERS  = `ARB_MAX_MASTERS;
    localparam int          PTR_W        = 2;
    localparam logic [31:0] TIMEOUT_DATA = `ARB_TIMEOUT_DATA;

    // Round-robin successor of a master index, wrapping at the configured count.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx, input int n);
        return (int'(idx) >= n - 1) ? '0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational one-hot pick of the first requester at or after ptr
module rr_priority_select
    import wishbone_master_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner
);

    always_comb begin
        logic found;
        int   idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wishbone_arbiter_defs.v
// rtl/wishbone_arbiter_defs.v - shared encodings and constants for the Wishbone master arbiter
`ifndef WISHBONE_ARBITER_DEFS_V
`define WISHBONE_ARBITER_DEFS_V

`define ARB_IDLE         2'd0
`define ARB_OWN          2'd1
`define ARB_GAP          2'd2
`define ARB_TIMEOUT_DATA 32'hDEAD_BEEF
`define ARB_MAX_MASTERS  4

`endif

// File: rtl/wishbone_master_arbiter.sv
// rtl/wishbone_master_arbiter.sv - round-robin cycle-locked Wishbone master arbiter
// Optional ack watchdog enabled by ARB_TIMEOUT_EN.
module wishbone_master_arbiter
    import wishbone_master_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
    input  logic [32*NUM_MASTERS-1:0] m_adr_i,
    input  logic [32*NUM_MASTERS-1:0] m_dat_i,
    output logic [32*NUM_MASTERS-1:0] m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_int_o,
    output logic                      s_we_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic [3:0]                s_sel_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    input  logic [31:0]               s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_int_i,
    output logic [NUM_MASTERS-1:0]    grant_o,
    output logic                      timeout_o
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("wishbone_master_arbiter: unsupported NUM_MASTERS or TIMEOUT_CYCLES");
    end

    arb_state_t               state_q, state_n;
    logic [NUM_MASTERS-1:0]   grant_q, grant_n;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_n;
    logic [NUM_MASTERS-1:0]   winner;
    logic [PTR_W-1:0]         owner_idx;
    logic                     to_ack;

    rr_priority_select #(.N(NUM_MASTERS)) u_select (
        .req    (m_cyc_i),
        .ptr    (rr_ptr_q),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_n;
            grant_q  <= grant_n;
            rr_ptr_q <= rr_ptr_n;
        end
    end

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) owner_idx = PTR_W'(i);
        end
    end

    // Grant is only non-zero in OWN, so the muxes below idle the bus in IDLE and GAP.
    always_comb begin
        state_n  = state_q;
        grant_n  = grant_q;
        rr_ptr_n = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    grant_n = winner;
                    state_n = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!s_cyc_o) begin
                    grant_n  = '0;
                    rr_ptr_n = next_ptr(owner_idx, NUM_MASTERS);
                    state_n  = ST_GAP;
                end
            end
            ST_GAP:  state_n = ST_IDLE;
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_comb begin
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_cyc_o = |(m_cyc_i & grant_q);
        s_stb_o = |(m_stb_i & m_cyc_i & grant_q);
        m_ack_o = grant_q & {NUM_MASTERS{s_ack_i | to_ack}};
        m_dat_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                s_we_o             = m_we_i[i];
                s_sel_o            = m_sel_i[4*i +: 4];
                s_adr_o            = m_adr_i[32*i +: 32];
                s_dat_o            = m_dat_i[32*i +: 32];
                m_dat_o[32*i +: 32] = to_ack ? TIMEOUT_DATA : s_dat_i;
            end
        end
    end

    assign m_int_o = {NUM_MASTERS{s_int_i}};
    assign grant_o = grant_q;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       timeout_q;

    assign to_ack = (state_q == ST_OWN) && s_stb_o && !s_ack_i && (to_cnt_q == 8'(TIMEOUT_CYCLES));

    // Counter is held at zero in IDLE so every fresh grant starts a clean window.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (s_ack_i || to_ack || state_q == ST_IDLE) begin
                to_cnt_q <= '0;
            end else if (s_stb_o) begin
                to_cnt_q <= to_cnt_q + 8'd1;
            end
            if (to_ack) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign to_ack    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// tb/tb_wishbone_master_arbiter.sv - directed self-checking bench for wishbone_master_arbiter
module tb_wishbone_master_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_we_i, m_cyc_i, m_stb_i;
    logic [4*N-1:0]  m_sel_i;
    logic [32*N-1:0] m_adr_i, m_dat_i;
    logic [32*N-1:0] m_dat_o;
    logic [N-1:0]    m_ack_o, m_int_o, grant_o;
    logic            s_we_o, s_cyc_o, s_stb_o, timeout_o;
    logic [3:0]      s_sel_o;
    logic [31:0]     s_adr_o, s_dat_o, s_dat_i;
    logic            s_ack_i, s_int_i;

    int tests_run    = 0;
    int tests_failed = 0;

    wishbone_master_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_we_i    (m_we_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_sel_i   (m_sel_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_int_o   (m_int_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_sel_o   (s_sel_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_int_i   (s_int_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int n, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_cyc_i[n]          = cyc;
        m_stb_i[n]          = stb;
        m_we_i[n]           = we;
        m_sel_i[4*n +: 4]   = 4'hF;
        m_adr_i[32*n +: 32] = adr;
        m_dat_i[32*n +: 32] = dat;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idle;
        int owner;
        logic early;

        m_we_i = '0; m_cyc_i = '0; m_stb_i = '0; m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_int_i = 1'b0;

        // Reset state
        rst = 1'b1;
        step(); step();
        check("rst_grant", grant_o, 0);
        check("rst_s_cyc", s_cyc_o, 0);
        check("rst_m_ack", m_ack_o, 0);
        check("rst_timeout", timeout_o, 0);
        rst = 1'b0;

        s_int_i = 1'b1; #1;
        check("int_high", m_int_o, 4'hF);
        s_int_i = 1'b0; #1;
        check("int_low", m_int_o, 4'h0);

        // Single write by master 2, acked on the third stb clock
        drive(2, 1, 1, 1, 32'h0100_0004, 32'h1234_5678); #1;
        check("m2_req_no_grant", grant_o, 0);
        check("m2_req_no_cyc", s_cyc_o, 0);
        step();
        check("m2_grant", grant_o, 4'b0100);
        check("m2_adr", s_adr_o, 32'h0100_0004);
        check("m2_dat", s_dat_o, 32'h1234_5678);
        check("m2_we", s_we_o, 1);
        check("m2_cyc_stb", {s_cyc_o, s_stb_o}, 2'b11);
        check("m2_ack_clk1", m_ack_o, 0);
        step();
        check("m2_ack_clk2", m_ack_o, 0);
        step();
        s_ack_i = 1'b1; s_dat_i = 32'h7777_0000; #1;
        check("m2_ack", m_ack_o, 4'b0100);
        step();
        s_ack_i = 1'b0;
        drive(2, 0, 0, 0, 32'h0, 32'h0); #1;
        check("m2_ack_once", m_ack_o, 0);
        check("m2_release_cyc", s_cyc_o, 0);
        step();
        check("m2_gap_grant", grant_o, 0);
        step();

        // All four request: round-robin 0,1,2,3,0 with a two-clock idle handover
        rst = 1'b1; step();
        rst = 1'b0;
        m_cyc_i = '1; m_stb_i = '1;
        step();
        for (int k = 0; k < 5; k++) begin
            owner = k % 4;
            check($sformatf("rr_grant_%0d", k), grant_o, 4'b0001 << owner);
            s_ack_i = 1'b1; m_cyc_i[owner] = 1'b0; m_stb_i[owner] = 1'b0; #1;
            check($sformatf("rr_ack_%0d", k), m_ack_o, 4'b0001 << owner);
            step();
            s_ack_i = 1'b0; m_cyc_i[owner] = 1'b1; m_stb_i[owner] = 1'b1; #1;
            idle = 0;
            while (grant_o == '0 && idle < 6) begin
                if (s_cyc_o !== 1'b0) check($sformatf("rr_gap_cyc_%0d", k), s_cyc_o, 0);
                idle++;
                step();
            end
            check($sformatf("rr_idle_%0d", k), idle, 2);
        end

        // Master 1 holds cyc for three reads while master 0 waits
        m_cyc_i = '0; m_stb_i = '0;
        rst = 1'b1; step();
        rst = 1'b0;
        drive(1, 1, 1, 0, 32'h0200_0010, 32'h0);
        step();
        drive(0, 1, 1, 1, 32'h0300_0000, 32'h5555_5555); #1;
        check("lock_grant", grant_o, 4'b0010);
        check("lock_adr", s_adr_o, 32'h0200_0010);
        for (int b = 0; b < 3; b++) begin
            s_ack_i = 1'b1; s_dat_i = 32'hA + b; #1;
            check($sformatf("lock_ack_%0d", b), m_ack_o, 4'b0010);
            check($sformatf("lock_dat1_%0d", b), m_dat_o[63:32], 32'hA + b);
            check($sformatf("lock_dat0_%0d", b), m_dat_o[31:0], 0);
            check($sformatf("lock_hold_%0d", b), grant_o, 4'b0010);
            step();
        end
        s_ack_i = 1'b0; #1;
        check("lock_still_m1", grant_o, 4'b0010);
        check("lock_dat0_idle", m_dat_o[31:0], 0);
        drive(1, 0, 0, 0, 32'h0, 32'h0); #1;
        check("lock_drop_cyc", s_cyc_o, 0);
        step();
        check("lock_gap", grant_o, 0);
        step();
        check("lock_idle", grant_o, 0);
        step();
        check("lock_m0_grant", grant_o, 4'b0001);

        // Reset while master 0 owns the bus mid-beat
        check("rstown_stb", s_stb_o, 1);
        rst = 1'b1;
        step();
        s_ack_i = 1'b1; #1;
        check("rstown_grant", grant_o, 0);
        check("rstown_cyc", s_cyc_o, 0);
        check("rstown_ack", m_ack_o, 0);
        rst = 1'b0; s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
        step();

        // Hung slave on master 3
        drive(3, 1, 1, 0, 32'h0400_0000, 32'h0);
        step();
        check("hang_grant", grant_o, 4'b1000);
        early = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (m_ack_o !== '0) early = 1'b1;
            step();
        end
        check("hang_no_early_ack", early, 0);
`ifdef ARB_TIMEOUT_EN
        check("to_ack", m_ack_o, 4'b1000);
        check("to_data", m_dat_o[127:96], 32'hDEAD_BEEF);
        step();
        check("to_flag", timeout_o, 1);
        check("to_ack_once", m_ack_o, 0);
        drive(3, 0, 0, 0, 32'h0, 32'h0);
        step(); step();
        check("to_sticky", timeout_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("to_cleared", timeout_o, 0);
`else
        check("hang_still_no_ack", m_ack_o, 0);
        check("hang_timeout_low", timeout_o, 0);
        check("hang_still_owner", grant_o, 4'b1000);
        drive(3, 0, 0, 0, 32'h0, 32'h0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
